// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the data-memory responder slice.
// Holds the responder FSM state encoding, the word geometry, the reset
// pattern of the top memory word and the byte-merge helper used on writes.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int          WORD_BYTES    = 4;
    localparam logic [31:0] RESET_PATTERN = 32'hFFFF_FFFF;

    // Replace only the bytes of old_w whose mask bit is set with bytes of new_w.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  mask
    );
        logic [31:0] res;
        res = old_w;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (mask[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_w[8*k +: 8];
            end
        end
        return res;
    endfunction

    // A word access is misaligned whenever the byte offset is non-zero.
    function automatic logic is_misaligned(input logic [1:0] byte_ofs);
        return (byte_ofs != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage for dmem_responder.
// Synchronous write with per-byte mask, registered read that returns zero in
// any cycle without a read strobe, and an asynchronous reset that loads the
// pattern word i = i, with the top word set to all ones.
module dmem_array
    import mips_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_mask,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rd_data_r;

    // Storage: reset pattern on rst_n, masked byte write on wr_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == DEPTH - 1) begin
                    mem_r[i] <= RESET_PATTERN;
                end else begin
                    mem_r[i] <= 32'(i);
                end
            end
        end else if (wr_en) begin
            mem_r[wr_idx] <= merge_bytes(mem_r[wr_idx], wr_data, wr_mask);
        end
    end

    // Read register: loads the addressed word on rd_en, otherwise clears to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= 32'h0000_0000;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_idx];
        end else begin
            rd_data_r <= 32'h0000_0000;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for the pipeline MEM stage.
// One request at a time: IDLE accepts, WAIT counts LATENCY cycles, RESP
// raises a one-cycle rvalid (with err for misaligned / out-of-range access).
// Optional feature macro: DMEM_BYTE_EN_EN -- when defined, be selects which
// bytes a write updates; when undefined, be is ignored and writes are full-word.
module dmem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [1:0]  S_IDLE  = IDLE;
    localparam logic [1:0]  S_WAIT  = WAIT;
    localparam logic [1:0]  S_RESP  = RESP;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [31:0] ADDR_LIMIT = 32'(WORD_BYTES * DEPTH);

    logic [1:0]  state_r;
    logic [3:0]  cnt_r;
    logic        ready_r;
    logic        rvalid_r;
    logic        err_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;

    logic        bad_s;
    logic        fire_s;
    logic        wr_en_s;
    logic        rd_en_s;
    logic [3:0]  wr_mask_s;
    logic [31:0] arr_rdata_s;

`ifdef DMEM_BYTE_EN_EN
    logic [3:0]  be_r;

    // Byte-enable capture on accept; applied to the write at commit time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            be_r <= 4'b0000;
        end else if ((state_r == S_IDLE) && req && ready_r) begin
            be_r <= be;
        end
    end

    assign wr_mask_s = be_r;
`else
    logic        unused_be_s;

    assign unused_be_s = ^be;
    assign wr_mask_s   = 4'b1111;
`endif

    // Access qualification and array strobes for the WAIT->RESP edge.
    always_comb begin
        bad_s   = 1'b0;
        fire_s  = 1'b0;
        wr_en_s = 1'b0;
        rd_en_s = 1'b0;
        if (is_misaligned(addr_r[1:0]) || (addr_r >= ADDR_LIMIT)) begin
            bad_s = 1'b1;
        end else begin
            bad_s = 1'b0;
        end
        if ((state_r == S_WAIT) && (cnt_r == 4'd0)) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
        if (fire_s && !bad_s) begin
            wr_en_s = we_r;
            rd_en_s = !we_r;
        end else begin
            wr_en_s = 1'b0;
            rd_en_s = 1'b0;
        end
    end

    // Request capture register: we/addr/wdata held for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
        end else if ((state_r == S_IDLE) && req && ready_r) begin
            we_r    <= we;
            addr_r  <= addr;
            wdata_r <= wdata;
        end
    end

    // Control FSM, latency counter and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            cnt_r    <= 4'd0;
            ready_r  <= 1'b1;
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                    if (req && ready_r) begin
                        state_r <= S_WAIT;
                        cnt_r   <= CNT_INIT;
                        ready_r <= 1'b0;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                S_WAIT: begin
                    ready_r <= 1'b0;
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        state_r  <= S_RESP;
                        rvalid_r <= 1'b1;
                        err_r    <= bad_s;
                    end
                end
                S_RESP: begin
                    state_r  <= S_IDLE;
                    ready_r  <= 1'b1;
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                end
                default: begin
                    state_r  <= S_IDLE;
                    cnt_r    <= 4'd0;
                    ready_r  <= 1'b1;
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_s),
        .wr_idx  (addr_r[AW+1:2]),
        .wr_data (wdata_r),
        .wr_mask (wr_mask_s),
        .rd_en   (rd_en_s),
        .rd_idx  (addr_r[AW+1:2]),
        .rd_data (arr_rdata_s)
    );

    assign ready  = ready_r;
    assign rvalid = rvalid_r;
    assign err    = err_r;
    assign rdata  = arr_rdata_s;

endmodule
